collision_edge_collector: RTL and testbench

Frame-level collision detector that sits directly upstream of the player motion block. It watches the per-pixel drawing requests of the player sprite and of the obstacle layer during the scan. It accumulates which player edges were touched and how many pixels overlapped. After each frame boundary it issues one clean `collision` pulse with a stable 4-bit `HitEdgeCode`, in the Left-Top-Right-Bottom bit order the motion block consumes.

---
 rtl/collision_edge_collector.sv | 112 +++++++++++
 tb/tb_collision_edge_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/collision_edge_collector.sv
// Per-frame player/obstacle overlap collector: accumulates touched player edges and
// overlap pixel count, then reports one collision pulse just after each frame boundary.
module collision_edge_collector #(
    parameter int OBJECT_WIDTH    = 32,
    parameter int OBJECT_HEIGHT   = 32,
    parameter int EDGE_MARGIN     = 4,
    parameter int MIN_HIT_PIXELS  = 2,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic        [10:0] pixelX,
    input  logic        [10:0] pixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    input  logic               playerDR,
    input  logic               obstacleDR,
    output logic               collision,
    output logic        [3:0]  HitEdgeCode,
    output logic        [15:0] hitCount
);

    localparam int CDW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [1:0] S_ARMED    = 2'd0;
    localparam logic [1:0] S_REPORT   = 2'd1;
    localparam logic [1:0] S_COOLDOWN = 2'd2;

    logic [11:0]    w_off_x;
    logic [11:0]    w_off_y;
    logic           w_valid;
    logic [3:0]     w_edge;
    logic           w_report;

    logic [1:0]     r_state;
    logic [CDW-1:0] r_cd;
    logic [3:0]     r_edge_acc;
    logic [15:0]    r_pix_acc;
    logic [3:0]     r_hit_edge;
    logic [15:0]    r_hit_count;

    // 12-bit two's-complement offsets; bit 11 set means the pixel lies left/above the sprite
    assign w_off_x = {1'b0, pixelX} - {topLeftX[10], topLeftX};
    assign w_off_y = {1'b0, pixelY} - {topLeftY[10], topLeftY};

    assign w_valid = playerDR && obstacleDR
                  && !w_off_x[11] && (w_off_x < 12'(OBJECT_WIDTH))
                  && !w_off_y[11] && (w_off_y < 12'(OBJECT_HEIGHT));

    assign w_edge = {4{w_valid}} & {
        (w_off_x <  12'(EDGE_MARGIN)),
        (w_off_y <  12'(EDGE_MARGIN)),
        (w_off_x >= 12'(OBJECT_WIDTH - EDGE_MARGIN)),
        (w_off_y >= 12'(OBJECT_HEIGHT - EDGE_MARGIN))
    };

    assign w_report = (r_pix_acc >= 16'(MIN_HIT_PIXELS)) && (r_edge_acc != 4'd0);

    // The frame-start cycle's own overlap seeds the new frame rather than the closing one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_acc  <= 4'd0;
            r_pix_acc   <= 16'd0;
            r_hit_count <= 16'd0;
        end else if (startOfFrame) begin
            r_edge_acc  <= w_edge;
            r_pix_acc   <= {15'd0, w_valid};
            r_hit_count <= r_pix_acc;
        end else begin
            r_edge_acc <= r_edge_acc | w_edge;
            if (w_valid && (r_pix_acc != 16'hFFFF)) begin
                r_pix_acc <= r_pix_acc + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_ARMED;
            r_cd       <= '0;
            r_hit_edge <= 4'd0;
        end else begin
            case (r_state)
                S_REPORT: begin
                    r_cd    <= CDW'(COOLDOWN_FRAMES);
                    r_state <= (COOLDOWN_FRAMES == 0) ? S_ARMED : S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    // The frame closing as cd hits zero is still discarded
                    if (startOfFrame) begin
                        r_cd <= r_cd - CDW'(1);
                        if (r_cd <= CDW'(1)) begin
                            r_state <= S_ARMED;
                        end
                    end
                end
                default: begin
                    if (startOfFrame && w_report) begin
                        r_state    <= S_REPORT;
                        r_hit_edge <= r_edge_acc;
                    end
                end
            endcase
        end
    end

    assign collision   = (r_state == S_REPORT);
    assign HitEdgeCode = r_hit_edge;
    assign hitCount    = r_hit_count;

endmodule

// File: tb/tb_collision_edge_collector.sv
// Scoreboard bench: a behavioural frame model queues the expected post-boundary outputs.
module tb_collision_edge_collector;

    localparam int W = 32, H = 32, M = 4, MINP = 2, CD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0, pixelY = '0;
    logic signed [10:0] topLeftX = '0, topLeftY = '0;
    logic        playerDR = 1'b0, obstacleDR = 1'b0;
    logic        collision;
    logic [3:0]  HitEdgeCode;
    logic [15:0] hitCount;

    collision_edge_collector #(
        .OBJECT_WIDTH(W), .OBJECT_HEIGHT(H), .EDGE_MARGIN(M),
        .MIN_HIT_PIXELS(MINP), .COOLDOWN_FRAMES(CD)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .playerDR(playerDR), .obstacleDR(obstacleDR),
        .collision(collision), .HitEdgeCode(HitEdgeCode), .hitCount(hitCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [20:0] exp_q[$];
    int tlx = 0, tly = 0;
    int m_cnt = 0, m_state = 0, m_cd = 0;
    logic [3:0] m_edge = 4'd0, m_code = 4'd0;
    logic sof_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit sof, input int x, input int y, input bit p, input bit o);
        int ox, oy;
        bit rep;
        logic [3:0] e;
        rep = 0;
        if (sof) begin
            rep = (m_state == 0) && (m_cnt >= MINP) && (m_edge != 4'd0);
            if (rep) m_code = m_edge;
            exp_q.push_back({rep, m_code, 16'(m_cnt)});
        end
        if (m_state == 1) begin
            m_state = (CD == 0) ? 0 : 2;
            m_cd = CD;
        end else if (sof) begin
            if (rep) m_state = 1;
            else if (m_state == 2) begin
                m_cd--;
                if (m_cd == 0) m_state = 0;
            end
        end
        if (sof) begin
            m_cnt = 0;
            m_edge = 4'd0;
        end
        ox = x - tlx;
        oy = y - tly;
        if (p && o && ox >= 0 && ox < W && oy >= 0 && oy < H) begin
            e = {ox < M, oy < M, ox >= W - M, oy >= H - M};
            m_edge |= e;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic cyc(input bit sof, input int x, input int y, input bit p, input bit o);
        startOfFrame = sof;
        pixelX = 11'(x);
        pixelY = 11'(y);
        topLeftX = 11'(tlx);
        topLeftY = 11'(tly);
        playerDR = p;
        obstacleDR = o;
        model_step(sof, x, y, p, o);
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input int x, input int y);
        cyc(0, x, y, 1, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic close_frame();
        cyc(1, 0, 0, 0, 0);
        idle(3);
    endtask

    always @(posedge clk) sof_seen <= reset ? 1'b0 : startOfFrame;

    always @(negedge clk) begin
        logic [20:0] e;
        if (!reset) begin
            if (sof_seen) begin
                if (exp_q.size() == 0) begin
                    check_eq("q_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("collision", 32'(collision), 32'(e[20]));
                    check_eq("edge_code", 32'(HitEdgeCode), 32'(e[19:16]));
                    check_eq("hit_count", 32'(hitCount), 32'(e[15:0]));
                    $display("frame close: coll=%0b code=%b count=%0d", collision, HitEdgeCode, hitCount);
                end
            end else begin
                check_eq("coll_idle", 32'(collision), 32'd0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_coll", 32'(collision), 32'd0);
        check_eq("rst_code", 32'(HitEdgeCode), 32'd0);
        check_eq("rst_count", 32'(hitCount), 32'd0);
        idle(2);
        // Quiet frames
        repeat (3) begin close_frame(); idle(2); end
        // Left-edge block at player (100,100)
        tlx = 100; tly = 100;
        hit(100, 110); hit(101, 110); hit(100, 111); hit(101, 111);
        cyc(0, 120, 120, 1, 0);
        close_frame();
        hit(100, 110); close_frame();
        hit(100, 110); hit(101, 111); close_frame();
        // Corner pixel: one alone is below threshold, two report right+bottom
        hit(131, 131); close_frame();
        hit(131, 131); hit(131, 131); close_frame();
        close_frame(); close_frame();
        // Repeated bottom-edge overlap through cooldown
        repeat (9) begin hit(115, 130); hit(116, 131); close_frame(); end
        // Interior-only: counted but no edge, no report
        hit(115, 115); hit(116, 116); close_frame();
        // Out-of-bounds overlaps, then a same-cycle overlap on the boundary
        hit(99, 110); hit(132, 110); hit(110, 99); hit(110, 132);
        cyc(1, 100, 100, 1, 1);
        idle(2);
        hit(101, 101); close_frame();
        close_frame(); close_frame();
        // Negative top-left
        tlx = -2; tly = -2;
        hit(0, 0); hit(29, 0); close_frame();
        hit(5, 5); close_frame();
        tlx = 100; tly = 100;
        hit(115, 115); close_frame();
        // Mid-frame reset after 10 overlap pixels
        for (int i = 0; i < 10; i++) hit(100 + i, 110);
        playerDR = 1'b0; obstacleDR = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_coll", 32'(collision), 32'd0);
        check_eq("mid_rst_code", 32'(HitEdgeCode), 32'd0);
        check_eq("mid_rst_count", 32'(hitCount), 32'd0);
        m_cnt = 0; m_edge = 4'd0; m_state = 0; m_cd = 0; m_code = 4'd0;
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
        hit(131, 131); hit(131, 131); hit(131, 131);
        close_frame();
        idle(5);
        check_eq("q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
